// File: rtl/comp2_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comp2_serial_pkg
// Brief    : Shared types and constants for the bit-serial comparator.
// Revision : 1.0 - initial release
// ============================================================================
package comp2_serial_pkg;

   // Controller state, 2-bit encoded
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit positions inside the 3-bit one-hot result bus
   localparam int RES_L = 0;
   localparam int RES_E = 1;
   localparam int RES_G = 2;

endpackage : comp2_serial_pkg
`default_nettype wire

// File: rtl/comp2_serial_ctrl_comp2.sv
`default_nettype none
// ============================================================================
// Module   : comp2
// Brief    : 1-bit magnitude comparator cell (L: a<b, E: a==b, G: a>b).
// Revision : 1.0 - initial release
// ============================================================================
module comp2 (
   input  logic i_a,
   input  logic i_b,
   output logic o_l,
   output logic o_e,
   output logic o_g
);

   // Purely combinational single-bit compare
   always_comb begin
      o_l = ~i_a & i_b;
      o_e = ~(i_a ^ i_b);
      o_g = i_a & ~i_b;
   end

endmodule : comp2
`default_nettype wire

// File: rtl/comp2_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comp2_serial_ctrl
// Brief    : Bit-serial WIDTH-bit magnitude comparator. Walks one comp2 cell
//            from MSB to LSB and returns a registered one-hot L/E/G result.
// Revision : 1.0 - initial release
// ============================================================================
module comp2_serial_ctrl
   import comp2_serial_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit SIGNED     = 1'b0,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             READY,
   output logic             BUSY,
   output logic             DONE,
   output logic             L,
   output logic             E,
   output logic             G
);

   localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_IW-1:0] c_IDX_MSB = c_IW'(WIDTH - 1);
   localparam logic [c_IW-1:0] c_IDX_ONE = c_IW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [c_IW-1:0]  r_idx;
   logic [c_IW-1:0]  w_idx_nxt;
   logic             r_msb;
   logic             r_miss;     // sticky: a mismatch was already seen
   logic             r_miss_l;   // L/G of that first mismatch
   logic             r_miss_g;
   logic             w_miss_set;
   logic [2:0]       r_res;
   logic [2:0]       w_res_nxt;
   logic             w_res_load;
   logic             w_accept;

   logic             w_cell_a;
   logic             w_cell_b;
   logic             w_cell_l;
   logic             w_cell_e;
   logic             w_cell_g;
   logic             w_l;
   logic             w_g;

   assign w_accept = START && (r_state == ST_IDLE);

   // Operand bit-select feeding the single comparator cell
   assign w_cell_a = r_a[r_idx];
   assign w_cell_b = r_b[r_idx];

   comp2 u_cell (
      .i_a (w_cell_a),
      .i_b (w_cell_b),
      .o_l (w_cell_l),
      .o_e (w_cell_e),
      .o_g (w_cell_g)
   );

   // Sign bit compares inverted: a 1 in A's MSB makes A the smaller value
   always_comb begin
      w_l = w_cell_l;
      w_g = w_cell_g;
      if (SIGNED && r_msb) begin
         w_l = w_cell_g;
         w_g = w_cell_l;
      end
   end

   // Next-state, index and result-capture decisions
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_res_nxt   = r_res;
      w_res_load  = 1'b0;
      w_miss_set  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_state_nxt = ST_SCAN;
               w_idx_nxt   = c_IDX_MSB;
            end
         end
         ST_SCAN: begin
            if (!w_cell_e && EARLY_EXIT) begin
               w_res_load        = 1'b1;
               w_res_nxt         = 3'b000;
               w_res_nxt[RES_L]  = w_l;
               w_res_nxt[RES_G]  = w_g;
               w_state_nxt       = ST_DONE;
            end else if (r_idx == '0) begin
               w_res_load = 1'b1;
               w_res_nxt  = 3'b000;
               if (r_miss) begin
                  w_res_nxt[RES_L] = r_miss_l;
                  w_res_nxt[RES_G] = r_miss_g;
               end else if (!w_cell_e) begin
                  w_res_nxt[RES_L] = w_l;
                  w_res_nxt[RES_G] = w_g;
               end else begin
                  w_res_nxt[RES_E] = 1'b1;
               end
               w_state_nxt = ST_DONE;
            end else begin
               w_idx_nxt  = r_idx - c_IDX_ONE;
               w_miss_set = !w_cell_e && !r_miss;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, operand, index, sticky-mismatch and result registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_msb    <= 1'b0;
         r_miss   <= 1'b0;
         r_miss_l <= 1'b0;
         r_miss_g <= 1'b0;
         r_res    <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_msb    <= 1'b1;
            r_miss   <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_g <= 1'b0;
         end else if (r_state == ST_SCAN) begin
            r_msb <= 1'b0;
         end
         if (w_miss_set) begin
            r_miss   <= 1'b1;
            r_miss_l <= w_l;
            r_miss_g <= w_g;
         end
         if (w_res_load) begin
            r_res <= w_res_nxt;
         end
      end
   end

   assign READY = (r_state == ST_IDLE);
   assign BUSY  = (r_state == ST_SCAN);
   assign DONE  = (r_state == ST_DONE);
   assign L     = r_res[RES_L];
   assign E     = r_res[RES_E];
   assign G     = r_res[RES_G];

endmodule : comp2_serial_ctrl
`default_nettype wire
